// File: rtl/gpio_od_ctrl.sv
// GPIO controller: push-pull/open-drain pads, synchronised and debounced
// inputs, rise/fall edge interrupts with write-one-to-clear status.
module gpio_od_ctrl #(
  parameter int NR_GPIOS = 8,
  parameter int DB_BITS  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_valid,
  input  logic                mem_wr,
  input  logic [2:0]          mem_addr,
  input  logic [31:0]         mem_wdata,
  output logic                mem_ready,
  output logic [31:0]         mem_rdata,
  input  logic [NR_GPIOS-1:0] gpio_di,
  output logic [NR_GPIOS-1:0] pad_oe,
  output logic [NR_GPIOS-1:0] pad_do,
  output logic                irq
);

  logic                r_ready;
  logic [31:0]         r_rdata;
  logic [NR_GPIOS-1:0] r_dout;
  logic [NR_GPIOS-1:0] r_oe;
  logic [NR_GPIOS-1:0] r_od;
  logic [NR_GPIOS-1:0] r_stable;
  logic [NR_GPIOS-1:0] r_rise;
  logic [NR_GPIOS-1:0] r_fall;
  logic [NR_GPIOS-1:0] r_stat;
  logic [DB_BITS-1:0]  r_db;
  logic [NR_GPIOS-1:0] r_sync1;
  logic [NR_GPIOS-1:0] r_sync2;
  logic [DB_BITS-1:0]  r_cnt [NR_GPIOS];

  logic                w_wr;
  logic [NR_GPIOS-1:0] w_wdat;
  logic [NR_GPIOS-1:0] w_diff;
  logic [NR_GPIOS-1:0] w_flip;
  logic [NR_GPIOS-1:0] w_set;
  logic [NR_GPIOS-1:0] w_w1c;
  logic [31:0]         w_rd;
  logic                w_unused;

  assign w_unused = ^mem_wdata;
  assign w_wr     = r_ready & mem_valid & mem_wr;
  assign w_wdat   = mem_wdata[NR_GPIOS-1:0];

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign irq       = |r_stat;

  // Open-drain pins only ever pull low: enable when driving a zero.
  assign pad_oe = r_oe & ~(r_od & r_dout);
  assign pad_do = r_dout & ~r_od;

  always_comb begin
    w_diff = r_sync2 ^ r_stable;
    w_flip = '0;
    for (int i = 0; i < NR_GPIOS; i++) begin
      w_flip[i] = w_diff[i] && (r_cnt[i] >= r_db);
    end
    w_set = w_flip & ((r_sync2 & r_rise) | (~r_sync2 & r_fall));
    w_w1c = (w_wr && mem_addr == 3'd6) ? w_wdat : '0;
  end

  always_comb begin
    w_rd = '0;
    unique case (mem_addr)
      3'd0: w_rd[NR_GPIOS-1:0] = r_dout;
      3'd1: w_rd[NR_GPIOS-1:0] = r_oe;
      3'd2: w_rd[NR_GPIOS-1:0] = r_od;
      3'd3: w_rd[NR_GPIOS-1:0] = r_stable;
      3'd4: w_rd[NR_GPIOS-1:0] = r_rise;
      3'd5: w_rd[NR_GPIOS-1:0] = r_fall;
      3'd6: w_rd[NR_GPIOS-1:0] = r_stat;
      3'd7: w_rd[DB_BITS-1:0]  = r_db;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= mem_valid & ~r_ready;
      r_rdata <= (mem_valid & ~r_ready & ~mem_wr) ? w_rd : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout <= '0;
      r_oe   <= '0;
      r_od   <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_db   <= '0;
    end else if (w_wr) begin
      case (mem_addr)
        3'd0:    r_dout <= w_wdat;
        3'd1:    r_oe   <= w_wdat;
        3'd2:    r_od   <= w_wdat;
        3'd4:    r_rise <= w_wdat;
        3'd5:    r_fall <= w_wdat;
        3'd7:    r_db   <= mem_wdata[DB_BITS-1:0];
        default: ;
      endcase
    end
  end

  // A new edge outranks a simultaneous write-one-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat <= '0;
    end else begin
      r_stat <= (r_stat & ~w_w1c) | w_set;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      for (int i = 0; i < NR_GPIOS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1  <= gpio_di;
      r_sync2  <= r_sync1;
      r_stable <= r_stable ^ w_flip;
      for (int i = 0; i < NR_GPIOS; i++) begin
        if (w_diff[i] && !w_flip[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

endmodule
